// File: rtl/pwls_channel_reg_writer.sv
// pwls_channel_reg_writer
//
// Byte-wide register writer for one PWLS synthesis channel. An 8-entry byte
// map is decoded into the channel parameter fields (octave, mantissa, detune,
// triangle offset, slope, amplitude, channel mode).
//
// Build option PWLS_REG_SHADOW_EN:
//   defined   - writes land in a shadow copy. A write carrying wr_commit_i
//               locks the writer. The next sample_strobe_i then copies the
//               whole shadow to the live outputs and unlocks the writer.
//               Parameters therefore only change on a sample boundary.
//   undefined - writes update the live registers directly. wr_ready_o is
//               tied to 1 and pending_o is tied to 0. No shadow exists.
//
// Handshake: a write is taken on a rising clk edge exactly when
// wr_valid_i && wr_ready_o. The requester keeps wr_valid_i and its
// address/data stable until that edge. wr_ready_o depends only on the
// registered state, never on wr_valid_i.
//
// All parameter outputs come straight from flops. There is no combinational
// path from the wr_* inputs to any parameter output.

module pwls_channel_reg_writer #(
  parameter int CHANNEL_MODE_BITS = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [2:0]                   wr_addr_i,
  input  logic [7:0]                   wr_data_i,
  input  logic                         wr_commit_i,
  input  logic                         sample_strobe_i,
  output logic [2:0]                   octave_o,
  output logic [9:0]                   mantissa_o,
  output logic [2:0]                   detune_exp_o,
  output logic signed [11:0]           tri_offset_o,
  output logic [3:0]                   slope_exp_o,
  output logic [8:0]                   slope_offset_o,
  output logic [9:0]                   amp_o,
  output logic [CHANNEL_MODE_BITS-1:0] channel_mode_o,
  output logic                         pending_o
);

  typedef struct packed {
    logic [2:0]                   octave;
    logic [9:0]                   mantissa;
    logic [2:0]                   detune_exp;
    logic [11:0]                  tri_offset;
    logic [3:0]                   slope_exp;
    logic [8:0]                   slope_offset;
    logic [9:0]                   amp;
    logic [CHANNEL_MODE_BITS-1:0] channel_mode;
  } params_t;

  // Merge one byte into a parameter set. Only the bits mapped by the
  // addressed byte change. Unmapped data bits are dropped.
  function automatic params_t apply_write(input params_t cur,
                                          input logic [2:0] addr,
                                          input logic [7:0] data);
    params_t nxt;
    nxt = cur;
    case (addr)
      3'd0: nxt.mantissa[7:0] = data;
      3'd1: begin
        nxt.detune_exp    = data[7:5];
        nxt.octave        = data[4:2];
        nxt.mantissa[9:8] = data[1:0];
      end
      3'd2: nxt.tri_offset[7:0] = data;
      3'd3: begin
        nxt.slope_exp        = data[7:4];
        nxt.tri_offset[11:8] = data[3:0];
      end
      3'd4: nxt.slope_offset[7:0] = data;
      3'd5: begin
        nxt.channel_mode    = data[CHANNEL_MODE_BITS:1];
        nxt.slope_offset[8] = data[0];
      end
      3'd6: nxt.amp[7:0] = data;
      3'd7: nxt.amp[9:8] = data[1:0];
    endcase
    return nxt;
  endfunction

  params_t live_q, live_d;
  logic    wr_accept;

`ifdef PWLS_REG_SHADOW_EN

  // OPEN: writes go to the shadow. LOCKED: a commit is waiting for the next
  // sample strobe, and new writes are held off. pending_o shows the state.
  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t  state_q, state_d;
  params_t shadow_q, shadow_d;

  // Next-state logic, the shadow merge, and the strobe-timed copy to live.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    live_d     = live_q;
    wr_ready_o = (state_q == ST_OPEN);
    pending_o  = (state_q == ST_LOCKED);
    wr_accept  = wr_valid_i && wr_ready_o;
    case (state_q)
      ST_OPEN: begin
        // A strobe seen while OPEN does nothing. A commit in the same cycle
        // therefore waits for the following strobe.
        if (wr_accept) begin
          shadow_d = apply_write(shadow_q, wr_addr_i, wr_data_i);
          if (wr_commit_i) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (sample_strobe_i) begin
          live_d  = shadow_q;
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_OPEN;
    endcase
  end

  // State, shadow and live registers. Reset clears all of them, which also
  // drops any uncommitted shadow contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OPEN;
      shadow_q <= '0;
      live_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

`else

  logic unused_ctrl;

  assign wr_ready_o  = 1'b1;
  assign pending_o   = 1'b0;
  assign wr_accept   = wr_valid_i;
  assign unused_ctrl = wr_commit_i ^ sample_strobe_i;

  // Direct mode: each accepted write is merged into the live set at once.
  always_comb begin
    live_d = live_q;
    if (wr_accept) begin
      live_d = apply_write(live_q, wr_addr_i, wr_data_i);
    end
  end

  // Live parameter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= '0;
    end else begin
      live_q <= live_d;
    end
  end

`endif

  assign octave_o       = live_q.octave;
  assign mantissa_o     = live_q.mantissa;
  assign detune_exp_o   = live_q.detune_exp;
  assign tri_offset_o   = live_q.tri_offset;
  assign slope_exp_o    = live_q.slope_exp;
  assign slope_offset_o = live_q.slope_offset;
  assign amp_o          = live_q.amp;
  assign channel_mode_o = live_q.channel_mode;

endmodule
